// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the MEM stage's load/store requests. Each request
// keeps busywait high for LATENCY cycles, counting the cycle it is presented.
// busywait then drops for one DONE cycle, in which D_out holds the load result
// and access_fault flags a misaligned access. Stores are committed with byte
// enables. Loads are sign- or zero-extended.
//
// Parameters:
//   DEPTH_WORDS  32-bit words of RAM (power of two). Upper address bits are
//                ignored, so out-of-range addresses alias into the array.
//   LATENCY      cycles busywait stays high per access (1..15).
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high
//   read_write    op code (0000 idle, 0001 SB, 0010 SH, 0011 SW,
//                 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU)
//   address       byte address
//   D_in          store data, LSB-aligned
//   D_out         extended load data (holds the last load value)
//   busywait      high while the request is not yet complete
//   access_fault  one-cycle pulse in DONE on a misaligned access
//   btn           raw push buttons (MMIO build only)
//   led           LED register (MMIO build only, otherwise 0)
//
// Optional feature: define MMIO_LED_BTN_EN to decode 0xFFFF_FF00 as the
// LED register and 0xFFFF_FF04 as the synchronised buttons.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  read_write,
  input  logic [31:0] address,
  input  logic [31:0] D_in,
  output logic [31:0] D_out,
  output logic        busywait,
  output logic        access_fault,
  input  logic [3:0]  btn,
  output logic [15:0] led
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [3:0] OP_LB    = 4'b1000;
  localparam logic [3:0] OP_LH    = 4'b1001;
  localparam logic [3:0] OP_LW    = 4'b1010;
  localparam logic [3:0] OP_LBU   = 4'b1100;
  localparam logic [3:0] OP_LHU   = 4'b1101;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [3:0]  op_reg;
  logic [31:0] addr_reg;
  logic [31:0] din_reg;
  logic        fault_reg;

  function automatic logic op_valid(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0010, 4'b0011,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_valid = 1'b1;
      default:                             op_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] word,
                                         input logic [3:0]  op,
                                         input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   extend = {{24{b[7]}}, b};
      OP_LBU:  extend = {24'b0, b};
      OP_LH:   extend = {{16{h[15]}}, h};
      OP_LHU:  extend = {16'b0, h};
      default: extend = word;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode. In IDLE the live inputs are used (so LATENCY=1 can commit
  // straight from IDLE); afterwards the latched copies are used.
  // ---------------------------------------------------------------------------
  logic        req_valid;
  logic [3:0]  cur_op;
  logic [31:0] cur_addr;
  logic [31:0] cur_din;
  logic        cur_load;
  logic [1:0]  cur_size;     // 0 byte, 1 half, 2 word
  logic        misaligned;
  logic [1:0]  eff_lo;       // low address bits after forcing alignment
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic [IDX_W-1:0] idx;
  logic        commit;
  logic        ram_sel;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_word;
  logic [31:0] src_word;

  assign req_valid = op_valid(read_write);
  assign cur_op    = (state_reg == IDLE) ? read_write : op_reg;
  assign cur_addr  = (state_reg == IDLE) ? address    : addr_reg;
  assign cur_din   = (state_reg == IDLE) ? D_in       : din_reg;
  assign cur_load  = cur_op[3];
  // Load sizes sit directly in op[1:0]; store sizes are offset by one.
  assign cur_size  = cur_load ? cur_op[1:0] : (cur_op[1:0] - 2'd1);

  assign misaligned = ((cur_size == 2'd1) && cur_addr[0]) ||
                      ((cur_size == 2'd2) && (cur_addr[1:0] != 2'b00));

  always_comb begin
    eff_lo  = 2'b00;
    byte_en = 4'b1111;
    wdata   = cur_din;
    case (cur_size)
      2'd0: begin
        eff_lo  = cur_addr[1:0];
        byte_en = 4'b0001 << cur_addr[1:0];
        wdata   = {4{cur_din[7:0]}};
      end
      2'd1: begin
        eff_lo  = {cur_addr[1], 1'b0};
        byte_en = 4'b0011 << {cur_addr[1], 1'b0};
        wdata   = {2{cur_din[15:0]}};
      end
      default: ;
    endcase
  end

  assign idx = cur_addr[IDX_W+1:2];

  // The access is performed on the edge that ends the last busy cycle.
  // cnt_reg counts busy cycles still to go, including the current one.
  assign commit = !reset &&
                  (((state_reg == IDLE) && req_valid && (LATENCY == 1)) ||
                   ((state_reg == ACCESS) && (cnt_reg == 4'd1)));

  assign busywait = !reset &&
                    ((state_reg == ACCESS) || ((state_reg == IDLE) && req_valid));

  assign access_fault = fault_reg;

  assign ram_we = byte_en & {4{commit && !cur_load && ram_sel}};
  assign ram_re = commit && cur_load && ram_sel;

  // ---------------------------------------------------------------------------
  // RAM: one byte-wide array per lane so each lane has a plain write enable.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (ram_we[gi]) begin
          lane_mem[idx] <= wdata[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_byte_reg <= '0;
        end else if (ram_re) begin
          rd_byte_reg <= lane_mem[idx];
        end
      end

      assign ram_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      addr_reg  <= '0;
      din_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      fault_reg <= commit && misaligned;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg   <= read_write;
            addr_reg <= address;
            din_reg  <= D_in;
            cnt_reg  <= CNT_INIT;
            // With LATENCY=1 the access already committed on this edge.
            state_reg <= (LATENCY == 1) ? DONE : ACCESS;
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Extension parameters of the most recent load; they survive later stores
  // so D_out keeps showing the last load value.
  logic [3:0] ld_op_reg;
  logic [1:0] ld_lo_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_op_reg <= OP_LW;
      ld_lo_reg <= 2'b00;
    end else if (commit && cur_load) begin
      ld_op_reg <= cur_op;
      ld_lo_reg <= eff_lo;
    end
  end

  assign D_out = extend(src_word, ld_op_reg, ld_lo_reg);

`ifdef MMIO_LED_BTN_EN
  // ---------------------------------------------------------------------------
  // LED / button window
  // ---------------------------------------------------------------------------
  logic        sel_led;
  logic        sel_btn;
  logic [31:0] led_reg;
  logic [3:0]  btn_meta_reg;
  logic [3:0]  btn_sync_reg;
  logic [31:0] mmio_word_reg;
  logic        ld_mmio_reg;

  assign sel_led = (cur_addr[31:2] == 30'h3FFF_FFC0);
  assign sel_btn = (cur_addr[31:2] == 30'h3FFF_FFC1);
  assign ram_sel = !(sel_led || sel_btn);

  always_ff @(posedge clk) begin
    if (reset) begin
      led_reg       <= '0;
      btn_meta_reg  <= '0;
      btn_sync_reg  <= '0;
      mmio_word_reg <= '0;
      ld_mmio_reg   <= 1'b0;
    end else begin
      btn_meta_reg <= btn;
      btn_sync_reg <= btn_meta_reg;
      if (commit && !cur_load && sel_led) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) begin
            led_reg[8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
      if (commit && cur_load) begin
        ld_mmio_reg   <= !ram_sel;
        mmio_word_reg <= sel_led ? led_reg : {28'b0, btn_sync_reg};
      end
    end
  end

  assign led      = led_reg[15:0];
  assign src_word = ld_mmio_reg ? mmio_word_reg : ram_word;
`else
  // No decode: every address lands in RAM and the button inputs are unused.
  logic unused_sig;

  assign ram_sel    = 1'b1;
  assign led        = '0;
  assign src_word   = ram_word;
  assign unused_sig = &{1'b0, btn, cur_addr[31:IDX_W+2]};
`endif

endmodule
